// File: rtl/bridge_rom_writer_pkg.sv
// Shared types for the ROM-window bridge writer: FSM states, FIFO entry layout and
// byte-lane helpers.
package bridge_rom_writer_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_ADDR_BITS = 30;

   typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} rom_wr_state_e;

   typedef struct packed {
      logic [WORD_ADDR_BITS-1:0]   word_addr;
      logic [8*BYTES_PER_WORD-1:0] data;
   } rom_wr_entry_t;

   // Byte offset within the word that a serialiser state emits.
   function automatic logic [1:0] byte_lane(rom_wr_state_e st);
      case (st)
         B1:      return 2'd1;
         B2:      return 2'd2;
         B3:      return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Big-endian: lane 0 is the most significant byte.
   function automatic logic [7:0] lane_byte(logic [31:0] w, logic [1:0] lane);
      case (lane)
         2'd0:    return w[31:24];
         2'd1:    return w[23:16];
         2'd2:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

endpackage

// File: rtl/bridge_rom_writer_if.sv
// Bridge-side and ROM-side signal bundle for the ROM writer leaf.
interface bridge_rom_writer_if #(
   parameter int unsigned ADDR_WIDTH = 20
);
   logic [31:0]           bridge_addr;
   logic                  bridge_wr;
   logic [31:0]           bridge_wr_data;
   logic                  bridge_rd;
   logic [31:0]           bridge_rd_data;
   logic                  rom_wr_en;
   logic [ADDR_WIDTH-1:0] rom_wr_addr;
   logic [7:0]            rom_wr_data;
   logic                  busy;
   logic                  overflow;
   logic [ADDR_WIDTH:0]   bytes_written;
   logic [15:0]           checksum;

   modport master (
      output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
      input  bridge_rd_data, rom_wr_en, rom_wr_addr, rom_wr_data,
      input  busy, overflow, bytes_written, checksum
   );

   modport slave (
      input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
      output bridge_rd_data, rom_wr_en, rom_wr_addr, rom_wr_data,
      output busy, overflow, bytes_written, checksum
   );
endinterface

// File: rtl/bridge_rom_writer_sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module bridge_rom_writer_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/bridge_rom_writer.sv
// ROM-window bridge leaf: buffers big-endian word writes and serialises them into
// byte writes on the program-memory port, with progress, overflow and checksum status.
module bridge_rom_writer
   import bridge_rom_writer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 20,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                clk_74a,
   input logic                reset,
   bridge_rom_writer_if.slave bus
);
   localparam logic [ADDR_WIDTH:0] BYTES_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   rom_wr_state_e         state_q, state_d;
   rom_wr_entry_t         push_entry, head_entry, hold_q, hold_d;
   logic                  fifo_full, fifo_empty, fifo_pop;
   logic                  busy;
   logic                  rom_en_q;
   logic [ADDR_WIDTH-1:0] rom_addr_q;
   logic [7:0]            rom_data_q;
   logic                  overflow_q;
   logic [ADDR_WIDTH:0]   bytes_q;
   logic [15:0]           checksum_q;
   logic [31:0]           rd_data_q;
   logic                  unused_addr_bits;
   logic                  unused_word_addr_hi;

   assign push_entry.word_addr = WORD_ADDR_BITS'(bus.bridge_addr[ADDR_WIDTH-1:2]);
   assign push_entry.data      = bus.bridge_wr_data;

   assign unused_addr_bits    = ^{bus.bridge_addr[31:ADDR_WIDTH], bus.bridge_addr[1:0]};
   assign unused_word_addr_hi = ^hold_d.word_addr[WORD_ADDR_BITS-1:ADDR_WIDTH-2];

   bridge_rom_writer_sync_fifo #(
      .WIDTH ($bits(rom_wr_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_74a),
      .reset (reset),
      .push  (bus.bridge_wr),
      .wdata (push_entry),
      .pop   (fifo_pop),
      .head  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Pop from IDLE or from B3 so consecutive words stream without a bubble.
   assign fifo_pop = !fifo_empty && ((state_q == IDLE) || (state_q == B3));
   assign busy     = !fifo_empty || (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (fifo_pop) begin
               hold_d  = head_entry;
               state_d = B0;
            end
         end
         B0: state_d = B1;
         B1: state_d = B2;
         B2: state_d = B3;
         B3: begin
            if (fifo_pop) begin
               hold_d  = head_entry;
               state_d = B0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_74a) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // ROM port is registered from the next state, so it lines up with state_q.
   always_ff @(posedge clk_74a) begin
      if (reset) begin
         rom_en_q   <= 1'b0;
         rom_addr_q <= '0;
         rom_data_q <= '0;
      end else begin
         rom_en_q   <= (state_d != IDLE);
         rom_addr_q <= {hold_d.word_addr[ADDR_WIDTH-3:0], byte_lane(state_d)};
         rom_data_q <= lane_byte(hold_d.data, byte_lane(state_d));
      end
   end

   always_ff @(posedge clk_74a) begin
      if (reset) begin
         overflow_q <= 1'b0;
         bytes_q    <= '0;
         checksum_q <= '0;
         rd_data_q  <= '0;
      end else begin
         if (bus.bridge_wr && fifo_full && !fifo_pop) overflow_q <= 1'b1;
         if (rom_en_q) begin
            if (bytes_q != BYTES_MAX) bytes_q <= bytes_q + 1'b1;
            checksum_q <= checksum_q + {8'h00, rom_data_q};
         end
         if (bus.bridge_rd) rd_data_q <= {checksum_q, 14'b0, overflow_q, busy};
      end
   end

   assign bus.rom_wr_en      = rom_en_q;
   assign bus.rom_wr_addr    = rom_addr_q;
   assign bus.rom_wr_data    = rom_data_q;
   assign bus.busy           = busy;
   assign bus.overflow       = overflow_q;
   assign bus.bytes_written  = bytes_q;
   assign bus.checksum       = checksum_q;
   assign bus.bridge_rd_data = rd_data_q;

endmodule

// File: tb/tb_bridge_rom_writer.sv
// Bench for bridge_rom_writer: a word-timeline model checked every cycle plus
// literal expectations for the directed scenarios.
module tb_bridge_rom_writer;

   logic clk = 1'b0;
   logic reset;

   bridge_rom_writer_if #(.ADDR_WIDTH(20)) bus ();

   bridge_rom_writer #(
      .ADDR_WIDTH (20),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_74a (clk),
      .reset   (reset),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Each accepted word: cycle it was written, cycle its first byte appears.
   typedef struct {
      int          push;
      int          start;
      logic [19:0] base;
      logic [31:0] data;
   } word_t;

   word_t       words[$];
   int          last_start = -100;
   int          cyc = 0;
   logic        m_ovf = 1'b0;
   logic [20:0] m_bytes = '0;
   logic [15:0] m_cs = '0;
   logic [31:0] m_rd = '0;
   bit          run = 1'b0;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   function automatic void exp_rom(input int t, output logic en, output logic [19:0] addr,
                                   output logic [7:0] data);
      en = 1'b0; addr = '0; data = '0;
      foreach (words[i]) begin
         if (t >= words[i].start && t < words[i].start + 4) begin
            int k;
            k    = t - words[i].start;
            en   = 1'b1;
            addr = words[i].base + 20'(k);
            data = 8'(words[i].data >> (8 * (3 - k)));
         end
      end
   endfunction

   function automatic logic exp_busy(input int t);
      foreach (words[i]) if (words[i].push < t && t <= words[i].start + 3) return 1'b1;
      return 1'b0;
   endfunction

   // Model: a word pushed in cycle c waits in the FIFO until cycle start-1.
   initial forever begin
      logic        en;
      logic [19:0] a;
      logic [7:0]  d;
      int          occ;
      bit          popnow;
      word_t       w;
      @(posedge clk);
      if (reset) begin
         words.delete();
         last_start = -100;
         m_ovf = 1'b0; m_bytes = '0; m_cs = '0; m_rd = '0;
      end else begin
         exp_rom(cyc, en, a, d);
         if (bus.bridge_rd) m_rd = {m_cs, 14'b0, m_ovf, exp_busy(cyc)};
         if (en) begin
            if (m_bytes != 21'h100000) m_bytes = m_bytes + 21'd1;
            m_cs = m_cs + {8'h00, d};
         end
         if (bus.bridge_wr) begin
            occ = 0; popnow = 1'b0;
            foreach (words[i]) begin
               if (words[i].push < cyc && words[i].start - 1 >= cyc) occ++;
               if (words[i].start - 1 == cyc) popnow = 1'b1;
            end
            if (occ < 4 || popnow) begin
               w.push  = cyc;
               w.start = (cyc + 2 > last_start + 4) ? cyc + 2 : last_start + 4;
               w.base  = bus.bridge_addr[19:0] & 20'hFFFFC;
               w.data  = bus.bridge_wr_data;
               words.push_back(w);
               last_start = w.start;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      cyc++;
   end

   initial forever begin
      logic        en;
      logic [19:0] a;
      logic [7:0]  d;
      @(negedge clk);
      if (run) begin
         exp_rom(cyc, en, a, d);
         check("rom_wr_en", 32'(bus.rom_wr_en), 32'(en));
         if (en) begin
            check("rom_wr_addr", 32'(bus.rom_wr_addr), 32'(a));
            check("rom_wr_data", 32'(bus.rom_wr_data), 32'(d));
         end
         check("busy", 32'(bus.busy), 32'(exp_busy(cyc)));
         check("overflow", 32'(bus.overflow), 32'(m_ovf));
         check("bytes_written", 32'(bus.bytes_written), 32'(m_bytes));
         check("checksum", 32'(bus.checksum), 32'(m_cs));
         check("bridge_rd_data", bus.bridge_rd_data, m_rd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [31:0] a, input logic [31:0] d);
      bus.bridge_wr = 1'b1; bus.bridge_addr = a; bus.bridge_wr_data = d;
      tick();
      bus.bridge_wr = 1'b0;
   endtask

   initial begin
      int          gaps;
      logic [20:0] bytes_base;
      logic [31:0] rdv;
      bus.bridge_addr = '0; bus.bridge_wr = 1'b0; bus.bridge_wr_data = '0; bus.bridge_rd = 1'b0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      run = 1'b1;
      check("reset_en", 32'(bus.rom_wr_en), 32'd0);
      check("reset_rd_data", bus.bridge_rd_data, 32'd0);

      // Single word
      write(32'h10, 32'hDEADBEEF);
      tick();
      check("single_b0_en", 32'(bus.rom_wr_en), 32'd1);
      check("single_b0_addr", 32'(bus.rom_wr_addr), 32'h10);
      check("single_b0_data", 32'(bus.rom_wr_data), 32'hDE);
      repeat (4) tick();
      check("single_busy_low", 32'(bus.busy), 32'd0);
      check("single_checksum", 32'(bus.checksum), 32'h0338);
      check("single_bytes", 32'(bus.bytes_written), 32'd4);

      // Readback with a concurrent write
      bus.bridge_rd = 1'b1;
      write(32'h20, 32'h11223344);
      bus.bridge_rd = 1'b0;
      check("readback", bus.bridge_rd_data, 32'h03380000);
      repeat (8) tick();

      // Back-to-back words at 4-cycle spacing
      gaps = 0;
      write(32'h0, 32'h00010203);
      tick();
      for (int k = 0; k < 16; k++) begin
         if (!bus.rom_wr_en) gaps++;
         if (k == 2 || k == 6 || k == 10) begin
            bus.bridge_wr = 1'b1;
            bus.bridge_addr = 32'(k + 2);
            bus.bridge_wr_data = 32'h40506070 + 32'(k);
         end
         tick();
         bus.bridge_wr = 1'b0;
      end
      check("b2b_gaps", 32'(gaps), 32'd0);
      check("b2b_overflow", 32'(bus.overflow), 32'd0);
      repeat (4) tick();

      // Overflow: seven consecutive writes, the last is dropped
      bytes_base = m_bytes;
      for (int i = 0; i < 7; i++) write(32'h400 + 32'(4 * i), 32'hA0A0A0A0 + 32'(i));
      check("ovf_set", 32'(bus.overflow), 32'd1);
      repeat (30) tick();
      check("ovf_sticky", 32'(bus.overflow), 32'd1);
      check("ovf_bytes", 32'(bus.bytes_written), 32'(bytes_base) + 32'd24);
      bus.bridge_rd = 1'b1;
      tick();
      bus.bridge_rd = 1'b0;
      rdv = bus.bridge_rd_data;
      check("ovf_rd_bit1", 32'(rdv[1]), 32'd1);
      check("ovf_rd_bit0", 32'(rdv[0]), 32'd0);

      // Unaligned address at the top of the window
      write(32'h000FFFFF, 32'h01020304);
      tick();
      check("high_addr_b0", 32'(bus.rom_wr_addr), 32'hFFFFC);
      check("high_data_b0", 32'(bus.rom_wr_data), 32'h01);
      repeat (3) tick();
      check("high_addr_b3", 32'(bus.rom_wr_addr), 32'hFFFFF);
      check("high_data_b3", 32'(bus.rom_wr_data), 32'h04);
      repeat (4) tick();

      // Reset during B1 with two words buffered; write in the reset cycle is ignored
      write(32'h100, 32'h11111111);
      write(32'h104, 32'h22222222);
      write(32'h108, 32'h33333333);
      reset = 1'b1;
      bus.bridge_wr = 1'b1; bus.bridge_addr = 32'h200; bus.bridge_wr_data = 32'h44444444;
      tick();
      reset = 1'b0; bus.bridge_wr = 1'b0;
      check("rst_en", 32'(bus.rom_wr_en), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_checksum", 32'(bus.checksum), 32'd0);
      check("rst_bytes", 32'(bus.bytes_written), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      repeat (3) tick();
      check("rst_stays_idle", 32'(bus.rom_wr_en), 32'd0);
      write(32'h300, 32'hA5C30F1E);
      tick();
      check("post_rst_en", 32'(bus.rom_wr_en), 32'd1);
      check("post_rst_addr", 32'(bus.rom_wr_addr), 32'h300);
      check("post_rst_data", 32'(bus.rom_wr_data), 32'hA5);
      repeat (6) tick();

      run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
